// File: rtl/demux_lanes.sv
// Word-rate to lane demultiplexer: routes each accepted word to the current lane and
// optionally (DEMUX_GROUP_EN) presents a full lane group at once.
module demux_lanes #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2
) (
  input  logic                       clk_nf,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       valid_in,
  input  logic                       lane_sync,
  output logic [LANES*WIDTH-1:0]     data_out,
  output logic [LANES-1:0]           valid_out,
  output logic [$clog2(LANES)-1:0]   lane_ptr,
  output logic                       group_done
);

  localparam int unsigned PTR_W  = $clog2(LANES);
  localparam int unsigned DATA_W = LANES * WIDTH;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("demux_lanes: WIDTH must be in 1..32");
  end
  if (LANES < 2 || LANES > 8) begin : g_bad_lanes
    $error("demux_lanes: LANES must be in 2..8");
  end

  logic [PTR_W-1:0]  ptr_q,   ptr_d;
  logic [DATA_W-1:0] dout_q,  dout_d;
  logic [LANES-1:0]  vout_q,  vout_d;
  logic              gdone_q, gdone_d;
`ifdef DEMUX_GROUP_EN
  localparam int unsigned STAGE_W = (LANES - 1) * WIDTH;
  logic [STAGE_W-1:0] stage_q, stage_d;
`endif

  // A sync in the same cycle as a word forces that word onto lane 0.
  logic [PTR_W-1:0] lane_sel_c;
  logic             last_c;

  assign lane_sel_c = lane_sync ? '0 : ptr_q;
  assign last_c     = (lane_sel_c == PTR_W'(LANES - 1));

  // Next-state: pointer, output lanes, strobes and group staging.
  always_comb begin
    ptr_d   = ptr_q;
    dout_d  = dout_q;
    vout_d  = '0;
    gdone_d = 1'b0;
`ifdef DEMUX_GROUP_EN
    stage_d = lane_sync ? '0 : stage_q;
`endif
    if (valid_in) begin
      ptr_d = last_c ? '0 : lane_sel_c + PTR_W'(1);
`ifdef DEMUX_GROUP_EN
      if (last_c) begin
        dout_d  = {data_in, stage_q};
        vout_d  = '1;
        gdone_d = 1'b1;
        stage_d = '0;
      end else begin
        for (int k = 0; k < int'(LANES) - 1; k++) begin
          if (lane_sel_c == PTR_W'(k)) begin
            stage_d[k*WIDTH +: WIDTH] = data_in;
          end
        end
      end
`else
      for (int k = 0; k < int'(LANES); k++) begin
        if (lane_sel_c == PTR_W'(k)) begin
          dout_d[k*WIDTH +: WIDTH] = data_in;
          vout_d[k]                = 1'b1;
        end
      end
      gdone_d = last_c;
`endif
    end else if (lane_sync) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk_nf or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      dout_q  <= '0;
      vout_q  <= '0;
      gdone_q <= 1'b0;
`ifdef DEMUX_GROUP_EN
      stage_q <= '0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      gdone_q <= gdone_d;
`ifdef DEMUX_GROUP_EN
      stage_q <= stage_d;
`endif
    end
  end

  assign data_out   = dout_q;
  assign valid_out  = vout_q;
  assign lane_ptr   = ptr_q;
  assign group_done = gdone_q;

endmodule

// File: tb/tb_demux_lanes.sv
// Directed bench for demux_lanes: a 4-lane and a 3-lane instance share stimulus.
module tb_demux_lanes;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        valid_in = 1'b0;
  logic        lane_sync = 1'b0;

  logic [31:0] d4;
  logic [3:0]  v4;
  logic [1:0]  p4;
  logic        g4;
  logic [23:0] d3;
  logic [2:0]  v3;
  logic [1:0]  p3;
  logic        g3;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  demux_lanes #(.WIDTH(8), .LANES(4)) u4 (
    .clk_nf(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .lane_sync(lane_sync), .data_out(d4), .valid_out(v4), .lane_ptr(p4),
    .group_done(g4)
  );

  demux_lanes #(.WIDTH(8), .LANES(3)) u3 (
    .clk_nf(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .lane_sync(lane_sync), .data_out(d3), .valid_out(v3), .lane_ptr(p3),
    .group_done(g3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [31:0] ed, input logic [3:0] ev,
                      input logic [1:0] ep, input logic eg);
    chk({tag, ".data"},  64'(d4), 64'(ed));
    chk({tag, ".valid"}, 64'(v4), 64'(ev));
    chk({tag, ".ptr"},   64'(p4), 64'(ep));
    chk({tag, ".gdone"}, 64'(g4), 64'(eg));
  endtask

  // Apply inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic s);
    valid_in  = v;
    data_in   = d;
    lane_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk4("rst_async", 32'h0, 4'h0, 2'd0, 1'b0);
    chk("rst_async.u3data", 64'(d3), 64'h0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int lane_tab [7] = '{0, 1, 2, 0, 1, 2, 0};
    valid_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk4("reset", 32'h0, 4'h0, 2'd0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;

`ifndef DEMUX_GROUP_EN
    // Burst through all four lanes and wrap.
    step(1'b1, 8'h11, 1'b0); chk4("b11", 32'h00000011, 4'b0001, 2'd1, 1'b0);
    step(1'b1, 8'h22, 1'b0); chk4("b22", 32'h00002211, 4'b0010, 2'd2, 1'b0);
    step(1'b1, 8'h33, 1'b0); chk4("b33", 32'h00332211, 4'b0100, 2'd3, 1'b0);
    step(1'b1, 8'h44, 1'b0); chk4("b44", 32'h44332211, 4'b1000, 2'd0, 1'b1);
    step(1'b1, 8'h55, 1'b0); chk4("b55", 32'h44332255, 4'b0001, 2'd1, 1'b0);

    // Realign with an idle sync, then a gap with X data.
    step(1'b0, 8'h00, 1'b1); chk4("sync_idle", 32'h44332255, 4'b0000, 2'd0, 1'b0);
    step(1'b1, 8'hA1, 1'b0); chk4("gA1", 32'h443322A1, 4'b0001, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hxx, 1'b0); chk4("gap", 32'h443322A1, 4'b0000, 2'd1, 1'b0);
    end
    step(1'b1, 8'hA2, 1'b0); chk4("gA2", 32'h4433A2A1, 4'b0010, 2'd2, 1'b0);

    // Mid-group sync abandons the partial group.
    step(1'b0, 8'h00, 1'b1); chk4("sync2", 32'h4433A2A1, 4'b0000, 2'd0, 1'b0);
    step(1'b1, 8'h01, 1'b0); chk4("s01", 32'h4433A201, 4'b0001, 2'd1, 1'b0);
    step(1'b1, 8'h02, 1'b0); chk4("s02", 32'h44330201, 4'b0010, 2'd2, 1'b0);
    step(1'b1, 8'h03, 1'b1); chk4("s03", 32'h44330203, 4'b0001, 2'd1, 1'b0);
    step(1'b1, 8'h04, 1'b0); chk4("s04", 32'h44330403, 4'b0010, 2'd2, 1'b0);
    step(1'b1, 8'h05, 1'b0); chk4("s05", 32'h44050403, 4'b0100, 2'd3, 1'b0);
    step(1'b1, 8'h06, 1'b0); chk4("s06", 32'h06050403, 4'b1000, 2'd0, 1'b1);

    // Asynchronous reset after two words of a group.
    step(1'b1, 8'h10, 1'b0); chk4("r10", 32'h06050410, 4'b0001, 2'd1, 1'b0);
    step(1'b1, 8'h20, 1'b0); chk4("r20", 32'h06052010, 4'b0010, 2'd2, 1'b0);
    valid_in = 1'b0;
    do_reset();
    step(1'b0, 8'h00, 1'b0); chk4("post_rst", 32'h0, 4'h0, 2'd0, 1'b0);
    step(1'b1, 8'h77, 1'b0); chk4("r77", 32'h00000077, 4'b0001, 2'd1, 1'b0);

    // Three-lane instance: seven words.
    step(1'b0, 8'h00, 1'b1);
    chk("u3.sync.ptr", 64'(p3), 64'h0);
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 8'(8'h31 + k), 1'b0);
      chk("u3.lane_data", 64'(d3[lane_tab[k]*8 +: 8]), 64'(8'h31 + k));
      chk("u3.valid", 64'(v3), 64'(3'b001 << lane_tab[k]));
      chk("u3.ptr", 64'(p3), 64'((lane_tab[k] + 1) % 3));
      chk("u3.gdone", 64'(g3), 64'(lane_tab[k] == 2));
    end
    chk("u3.final", 64'(d3), 64'h363537);
    step(1'b0, 8'h00, 1'b0);
    chk("u3.idle_valid", 64'(v3), 64'h0);
`else
    // Group mode: outputs change only when the last lane word is accepted.
    step(1'b1, 8'hDE, 1'b0); chk4("gDE", 32'h0, 4'b0000, 2'd1, 1'b0);
    step(1'b1, 8'hAD, 1'b0); chk4("gAD", 32'h0, 4'b0000, 2'd2, 1'b0);
    chk("u3.grp.data", 64'(d3), 64'h0);
    step(1'b1, 8'hBE, 1'b0); chk4("gBE", 32'h0, 4'b0000, 2'd3, 1'b0);
    chk("u3.grp.data", 64'(d3), 64'hBEADDE);
    chk("u3.grp.valid", 64'(v3), 64'h7);
    step(1'b1, 8'hEF, 1'b0); chk4("gEF", 32'hEFBEADDE, 4'b1111, 2'd0, 1'b1);
    step(1'b0, 8'hxx, 1'b0); chk4("gidle", 32'hEFBEADDE, 4'b0000, 2'd0, 1'b0);

    // Mid-group sync drops staged words, data_out untouched.
    step(1'b1, 8'h11, 1'b0); chk4("gs11", 32'hEFBEADDE, 4'b0000, 2'd1, 1'b0);
    step(1'b1, 8'h22, 1'b0); chk4("gs22", 32'hEFBEADDE, 4'b0000, 2'd2, 1'b0);
    step(1'b0, 8'h00, 1'b1); chk4("gsync", 32'hEFBEADDE, 4'b0000, 2'd0, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h66, 1'b0); chk4("g66", 32'h66554433, 4'b1111, 2'd0, 1'b1);

    // Reset mid-group zeroes everything; no pulse afterwards.
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    valid_in = 1'b0;
    do_reset();
    step(1'b0, 8'h00, 1'b0); chk4("post_rst", 32'h0, 4'h0, 2'd0, 1'b0);
    step(1'b1, 8'h77, 1'b0); chk4("r77", 32'h0, 4'h0, 2'd1, 1'b0);
    step(1'b1, 8'h78, 1'b0);
    step(1'b1, 8'h79, 1'b0);
    step(1'b1, 8'h7A, 1'b0); chk4("r7A", 32'h7A797877, 4'b1111, 2'd0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
